// File: rtl/cu_pkg.sv
// Shared types and constants for computational_unit_p: ALU functions, bus sources,
// write-enable bit positions and the multiply engine states.
package cu_pkg;

  typedef enum logic [2:0] {
    FN_NEG  = 3'd0,
    FN_SUB  = 3'd1,
    FN_ADD  = 3'd2,
    FN_MULH = 3'd3,
    FN_MULL = 3'd4,
    FN_XOR  = 3'd5,
    FN_AND  = 3'd6,
    FN_NOT  = 3'd7
  } alu_func_e;

  localparam logic [3:0] SRC_X0   = 4'd0;
  localparam logic [3:0] SRC_X1   = 4'd1;
  localparam logic [3:0] SRC_Y0   = 4'd2;
  localparam logic [3:0] SRC_Y1   = 4'd3;
  localparam logic [3:0] SRC_R    = 4'd4;
  localparam logic [3:0] SRC_M    = 4'd5;
  localparam logic [3:0] SRC_I    = 4'd6;
  localparam logic [3:0] SRC_DM   = 4'd7;
  localparam logic [3:0] SRC_IR   = 4'd8;
  localparam logic [3:0] SRC_PINS = 4'd9;

  localparam int RE_X0 = 0;
  localparam int RE_X1 = 1;
  localparam int RE_Y0 = 2;
  localparam int RE_Y1 = 3;
  localparam int RE_R  = 4;
  localparam int RE_M  = 5;
  localparam int RE_I  = 6;
  localparam int RE_O  = 8;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/cu_seq_mul.sv
// Sequential shift-add multiplier with a one-entry product cache; a miss stalls
// the controller for DATA_W+1 cycles, after which the held instruction hits.
module cu_seq_mul
  import cu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mul_op,
  input  logic [DATA_W-1:0]     x,
  input  logic [DATA_W-1:0]     y,
  output logic [2*DATA_W-1:0]   product,
  output logic                  mul_stall
);

  localparam int CW = $clog2(DATA_W + 1);

  mul_state_e              state, state_nx;
  logic [DATA_W-1:0]       opx, opy, mplier;
  logic [2*DATA_W-1:0]     acc, mcand;
  logic [CW-1:0]           cnt;
  logic                    prod_valid, hit, start;

  assign hit     = prod_valid && (opx == x) && (opy == y);
  assign product = acc;

  always_comb begin
    state_nx  = state;
    mul_stall = 1'b0;
    start     = 1'b0;
    case (state)
      MS_IDLE: begin
        if (mul_op && !hit) begin
          mul_stall = 1'b1;
          start     = 1'b1;
          state_nx  = MS_RUN;
        end
      end
      MS_RUN: begin
        mul_stall = 1'b1;
        if (cnt == CW'(1)) state_nx = MS_IDLE;
      end
      default: state_nx = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MS_IDLE;
    else     state <= state_nx;
  end

  // acc doubles as the cached product once prod_valid is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opx        <= '0;
      opy        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      prod_valid <= 1'b0;
    end else if (start) begin
      opx        <= x;
      opy        <= y;
      acc        <= '0;
      mcand      <= {{DATA_W{1'b0}}, x};
      mplier     <= y;
      cnt        <= CW'(DATA_W);
      prod_valid <= 1'b0;
    end else if (state == MS_RUN) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) prod_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/computational_unit_p.sv
// Nibble-processor datapath: X/Y/M/I/R/O registers, bus source mux and ALU with zero/carry flags.
// CU_SEQ_MUL_EN selects the stalling sequential multiplier; otherwise multiply is combinational.
module computational_unit_p
  import cu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic                x_sel,
  input  logic                y_sel,
  input  logic                i_sel,
  input  logic [3:0]          nibble_ir,
  input  logic [3:0]          source_sel,
  input  logic [8:0]          reg_en,
  input  logic [DATA_W-1:0]   dm,
  input  logic [DATA_W-1:0]   i_pins,
  output logic [DATA_W-1:0]   data_bus,
  output logic [DATA_W-1:0]   x0,
  output logic [DATA_W-1:0]   x1,
  output logic [DATA_W-1:0]   y0,
  output logic [DATA_W-1:0]   y1,
  output logic [DATA_W-1:0]   m,
  output logic [DATA_W-1:0]   i,
  output logic [DATA_W-1:0]   r,
  output logic [DATA_W-1:0]   o_reg,
  output logic                r_eq_0,
  output logic                r_carry,
  output logic [2*DATA_W-1:0] from_cu,
  output logic                mul_stall
);

  alu_func_e             func;
  logic                  ir3, alu_c, unused_bits;
  logic [DATA_W-1:0]     alu_x, alu_y, alu_out;
  logic [DATA_W:0]       sum;
  logic [2*DATA_W-1:0]   product;

  assign func        = alu_func_e'(nibble_ir[2:0]);
  assign ir3         = nibble_ir[3];
  assign alu_x       = x_sel ? x1 : x0;
  assign alu_y       = y_sel ? y1 : y0;
  assign sum         = {1'b0, alu_x} + {1'b0, alu_y};
  assign from_cu     = {x1, x0};
  assign unused_bits = reg_en[7];

`ifdef CU_SEQ_MUL_EN
  logic mul_op;
  assign mul_op = reg_en[RE_R] && (func == FN_MULH || func == FN_MULL) && !ir3;

  cu_seq_mul #(.DATA_W(DATA_W)) u_seq_mul (
    .clk       (clk),
    .rst       (sync_reset),
    .mul_op    (mul_op),
    .x         (alu_x),
    .y         (alu_y),
    .product   (product),
    .mul_stall (mul_stall)
  );
`else
  assign product   = {{DATA_W{1'b0}}, alu_x} * {{DATA_W{1'b0}}, alu_y};
  assign mul_stall = 1'b0;
`endif

  always_comb begin
    data_bus = '0;
    case (source_sel)
      SRC_X0:   data_bus = x0;
      SRC_X1:   data_bus = x1;
      SRC_Y0:   data_bus = y0;
      SRC_Y1:   data_bus = y1;
      SRC_R:    data_bus = r;
      SRC_M:    data_bus = m;
      SRC_I:    data_bus = i;
      SRC_DM:   data_bus = dm;
      SRC_IR:   data_bus = DATA_W'(nibble_ir);
      SRC_PINS: data_bus = i_pins;
      default:  data_bus = '0;
    endcase
  end

  always_comb begin
    alu_out = '0;
    alu_c   = 1'b0;
    case (func)
      FN_NEG: begin
        if (ir3) alu_out = r;
        else begin
          alu_out = -alu_x;
          alu_c   = |alu_x;
        end
      end
      FN_SUB: begin
        alu_out = alu_x - alu_y;
        alu_c   = alu_x < alu_y;
      end
      FN_ADD:  {alu_c, alu_out} = sum;
      FN_MULH: alu_out = product[2*DATA_W-1:DATA_W];
      FN_MULL: alu_out = product[DATA_W-1:0];
      FN_XOR:  alu_out = alu_x ^ alu_y;
      FN_AND:  alu_out = alu_x & alu_y;
      FN_NOT:  alu_out = ir3 ? r : ~alu_x;
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      x0      <= '0;
      x1      <= '0;
      y0      <= '0;
      y1      <= '0;
      m       <= '0;
      i       <= '0;
      r       <= '0;
      o_reg   <= '0;
      r_eq_0  <= 1'b1;
      r_carry <= 1'b0;
    end else begin
      if (reg_en[RE_X0]) x0 <= data_bus;
      if (reg_en[RE_X1]) x1 <= data_bus;
      if (reg_en[RE_Y0]) y0 <= data_bus;
      if (reg_en[RE_Y1]) y1 <= data_bus;
      if (reg_en[RE_M])  m  <= data_bus;
      if (reg_en[RE_I])  i  <= i_sel ? i + m : data_bus;
      if (reg_en[RE_O])  o_reg <= data_bus;
      // a stalled multiply keeps r and its flags until the cached product is ready
      if (reg_en[RE_R] && !mul_stall) begin
        r       <= alu_out;
        r_eq_0  <= (alu_out == '0);
        r_carry <= alu_c;
      end
    end
  end

endmodule
